sb_reg_file: RTL

- Parametrised, clocked general/predicate/float register file with an integrated scoreboard. It replaces the combinational per-class register files in the decode stage.
- Provides NRD read ports with same-cycle writeback bypass and one writeback port.
- Keeps per-register busy bits that are set when an instruction issues and cleared at writeback. Decode uses these to stall on RAW and WAW hazards.
- One instance is used per register class: preg uses WIDTH=1, NREGS=4; greg and freg use WIDTH=32, NREGS=16.

---
 rtl/sb_pkg.sv | 28 ++
 rtl/sb_busy_vec.sv | 50 +++++
 rtl/sb_reg_file.sv | 111 +++++++++++
 3 files changed

// File: rtl/sb_pkg.sv
// sb_pkg: shared constants and types for the scoreboarded register files.
// Class sizes and the writeback class-select encoding live here.
package sb_pkg;

    function automatic int sb_clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1)
            r++;
        return r;
    endfunction

    localparam int PREG_N = 4;
    localparam int GREG_N = 16;
    localparam int FREG_N = 16;
    localparam int REG_W  = 32;

    localparam int WB_CLS_W = 3;

    // one-hot writeback class select
    typedef enum logic [WB_CLS_W-1:0] {
        WB_NONE = 3'b000,
        WB_PREG = 3'b001,
        WB_GREG = 3'b010,
        WB_FREG = 3'b100
    } wb_cls_e;

endpackage

// File: rtl/sb_busy_vec.sv
// sb_busy_vec: per-register busy bits with flush/clear/set priority
// and a registered popcount of the busy vector.
module sb_busy_vec
    import sb_pkg::*;
#(
    parameter int NREGS = 16,
    parameter int AW    = sb_clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             clr_en,
    input  logic [AW-1:0]    clr_addr,
    input  logic             set_en,
    input  logic [AW-1:0]    set_addr,
    output logic [NREGS-1:0] busy,
    output logic [AW:0]      pending_cnt
);

    logic [NREGS-1:0] busy_nxt;
    logic [AW:0]      cnt_nxt;

    // set is applied last so a new owner wins over a same-cycle clear
    always_comb begin
        busy_nxt = busy;
        if (flush)
            busy_nxt = '0;
        else if (clr_en)
            busy_nxt[clr_addr] = 1'b0;
        if (set_en)
            busy_nxt[set_addr] = 1'b1;
    end

    always_comb begin
        cnt_nxt = '0;
        for (int i = 0; i < NREGS; i++)
            cnt_nxt = cnt_nxt + {{AW{1'b0}}, busy_nxt[i]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy        <= '0;
            pending_cnt <= '0;
        end else begin
            busy        <= busy_nxt;
            pending_cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/sb_reg_file.sv
// sb_reg_file: clocked register file with writeback bypass and an
// integrated scoreboard for RAW/WAW issue stalls.
module sb_reg_file
    import sb_pkg::*;
#(
    parameter int NREGS   = 16,
    parameter int WIDTH   = 32,
    parameter int NRD     = 2,
    parameter int R0_ZERO = 0,
    parameter int AW      = sb_clog2(NREGS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NRD-1:0]       rd_en,
    input  logic [NRD*AW-1:0]    rd_addr,
    output logic [NRD*WIDTH-1:0] rd_data,
    output logic [NRD-1:0]       rd_busy,
    input  logic                 issue_valid,
    input  logic                 issue_wr,
    input  logic [AW-1:0]        issue_addr,
    output logic                 stall,
    input  logic                 wb_valid,
    input  logic [AW-1:0]        wb_addr,
    input  logic [WIDTH-1:0]     wb_data,
    input  logic                 flush,
    output logic [AW:0]          pending_cnt,
    output logic                 wb_err
);

    logic [WIDTH-1:0] regs [NREGS];
    logic [NREGS-1:0] busy;

    logic wb_r0;
    logic iss_r0;
    logic wb_live;
    logic waw;
    logic raw;
    logic accept;
    logic set_en;

    assign wb_r0   = (R0_ZERO != 0) && (wb_addr == '0);
    assign iss_r0  = (R0_ZERO != 0) && (issue_addr == '0);
    assign wb_live = wb_valid && !wb_r0;

    // data writes are never squashed by flush
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
        end else if (wb_live) begin
            regs[wb_addr] <= wb_data;
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [AW-1:0]    a;
        logic             a_r0;
        logic [WIDTH-1:0] d;
        logic             b;

        assign a    = rd_addr[p*AW +: AW];
        assign a_r0 = (R0_ZERO != 0) && (a == '0);

        always_comb begin
            d = regs[a];
            b = busy[a];
            if (a_r0) begin
                d = '0;
                b = 1'b0;
            end else if (wb_valid && (wb_addr == a)) begin
                d = wb_data;
                b = 1'b0;
            end
        end

        assign rd_data[p*WIDTH +: WIDTH] = d;
        assign rd_busy[p]                = b;
    end

    // a destination being written back this cycle frees up in time
    assign waw = issue_wr && busy[issue_addr] &&
                 !(wb_live && (wb_addr == issue_addr));
    assign raw = |(rd_en & rd_busy);

    assign stall  = issue_valid && (raw || waw);
    assign accept = issue_valid && !stall && !flush;
    assign set_en = accept && issue_wr && !iss_r0;

    sb_busy_vec #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_busy (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .clr_en      (wb_live),
        .clr_addr    (wb_addr),
        .set_en      (set_en),
        .set_addr    (issue_addr),
        .busy        (busy),
        .pending_cnt (pending_cnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            wb_err <= 1'b0;
        else if (wb_live && !flush && !busy[wb_addr])
            wb_err <= 1'b1;
    end

endmodule
